seq_alu: RTL and testbench

Parametrised, registered ALU for the multi-cycle datapath: one start/done handshake covers single-cycle boolean, shift, add/sub and compare ops and iterative multiply/divide. The core is WIDTH bits wide and produces a second result word, Y_hi, holding the product high half or the remainder. It sits between the register-file read stage and the HI/LO / writeback registers, and the control FSM sequences it by polling `ready` and `done`.

---
 rtl/seq_alu_pkg.sv | 44 ++++
 rtl/seq_alu_muldiv_iter.sv | 190 +++++++++++++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, iteration FSM states and
// opcode class decoding. Optional divider controlled by SEQ_ALU_DIV_EN.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_AND   = 5'b00000,
        OP_OR    = 5'b00001,
        OP_XOR   = 5'b00010,
        OP_NOR   = 5'b00011,
        OP_PASSA = 5'b00100,
        OP_SLL   = 5'b01000,
        OP_SRL   = 5'b01001,
        OP_SRA   = 5'b01010,
        OP_ADD   = 5'b10000,
        OP_SUB   = 5'b10001,
        OP_SLT   = 5'b10010,
        OP_SLTU  = 5'b10011,
        OP_MULT  = 5'b11000,
        OP_MULTU = 5'b11001,
        OP_DIV   = 5'b11010,
        OP_DIVU  = 5'b11011
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        FINISH = 2'b10
    } md_state_e;

    // Opcode class field: bits [4:3] select logic/shift/arith/muldiv.
    localparam int         OP_CLASS_HI  = 4;
    localparam int         OP_CLASS_LO  = 3;
    localparam logic [1:0] CLASS_MULDIV = 2'b11;

    // True for opcodes that go through the iterative unit.
    function automatic logic is_muldiv_op(input logic [4:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op[OP_CLASS_HI:OP_CLASS_LO] == CLASS_MULDIV) && (op[2] == 1'b0);
`else
        return (op[OP_CLASS_HI:OP_CLASS_LO] == CLASS_MULDIV) && (op[2:1] == 2'b00);
`endif
    endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative multiply/divide unit: magnitudes are iterated one bit per cycle,
// signs are re-applied in FINISH. Divider present only with SEQ_ALU_DIV_EN.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_z,
    output logic             res_v,
    output logic             res_n
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
    logic             uns_q, uns_d, neg_q, neg_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef SEQ_ALU_DIV_EN
    logic             div_q, div_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   div_shift, div_trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;
`else
    logic             unused_op_div;
    assign unused_op_div = op_div;
`endif

    assign a_neg   = ~op_unsigned & a[WIDTH-1];
    assign b_neg   = ~op_unsigned & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    // Shift-add step: conditionally add multiplicand to the high half, shift right.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
`ifdef SEQ_ALU_DIV_EN
    // Restoring step: shift next dividend bit into the partial remainder, trial-subtract.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, m_q};
`endif

    // Next-state, operand capture and one iteration per BUSY cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        uns_d   = uns_q;
        neg_d   = neg_q;
`ifdef SEQ_ALU_DIV_EN
        div_d   = div_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    hi_d    = '0;
                    uns_d   = op_unsigned;
                    neg_d   = a_neg ^ b_neg;
                    lo_d    = b_mag;
                    m_d     = a_mag;
`ifdef SEQ_ALU_DIV_EN
                    div_d   = op_div;
                    rneg_d  = a_neg;
                    a_d     = a;
                    dz_d    = (b == '0);
                    ovf_d   = ~op_unsigned && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                    if (op_div) begin
                        lo_d = a_mag;
                        m_d  = b_mag;
                    end
`endif
                end
            end
            BUSY: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
                if (div_q) begin
                    if (!div_trial[WIDTH]) begin
                        hi_d = div_trial[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sign fix-up and flags, valid while in FINISH.
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        res_lo   = prod_fix[WIDTH-1:0];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_z    = (prod_fix == '0);
        res_n    = ~uns_q & prod_fix[2*WIDTH-1];
        res_v    = 1'b0;
`ifdef SEQ_ALU_DIV_EN
        quo_fix  = neg_q ? -lo_q : lo_q;
        rem_fix  = rneg_q ? -hi_q : hi_q;
        if (div_q) begin
            res_v = 1'b0;
            if (dz_q) begin
                res_lo = '1;
                res_hi = a_q;
                res_v  = 1'b1;
            end else if (ovf_q) begin
                res_lo = {1'b1, {(WIDTH-1){1'b0}}};
                res_hi = '0;
                res_v  = 1'b1;
            end else begin
                res_lo = quo_fix;
                res_hi = rem_fix;
            end
            res_z = (res_lo == '0);
            res_n = res_lo[WIDTH-1];
        end
`endif
    end

    assign busy = (state_q != IDLE);
    assign fin  = (state_q == FINISH);

    // Iteration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            uns_q   <= 1'b0;
            neg_q   <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            a_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            uns_q   <= uns_d;
            neg_q   <= neg_d;
`ifdef SEQ_ALU_DIV_EN
            div_q   <= div_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake: single-cycle ops computed here,
// multiply/divide delegated to muldiv_iter. Divider enabled by SEQ_ALU_DIV_EN.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ALUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_hi,
    output logic             z,
    output logic             v,
    output logic             n
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d, y_comb, sum, diff;
    logic             z_q, z_d, v_q, v_d, n_q, n_d, done_q, done_d, v_comb;
    logic [SHW-1:0]   shamt;
    logic             md_busy, md_fin, md_z, md_v, md_n, md_start, op_is_md;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign op_is_md = is_muldiv_op(ALUOp);
    assign ready    = ~md_busy;
    assign md_start = start & ready & op_is_md;

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .reset       (reset),
        .start       (md_start),
        .op_div      (ALUOp[1]),
        .op_unsigned (ALUOp[0]),
        .a           (A),
        .b           (B),
        .busy        (md_busy),
        .fin         (md_fin),
        .res_lo      (md_lo),
        .res_hi      (md_hi),
        .res_z       (md_z),
        .res_v       (md_v),
        .res_n       (md_n)
    );

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[SHW-1:0];

    // Single-cycle result and overflow; unknown opcodes give zero.
    always_comb begin
        y_comb = '0;
        v_comb = 1'b0;
        case (ALUOp)
            OP_AND:   y_comb = A & B;
            OP_OR:    y_comb = A | B;
            OP_XOR:   y_comb = A ^ B;
            OP_NOR:   y_comb = ~(A | B);
            OP_PASSA: y_comb = A;
            OP_SLL:   y_comb = A << shamt;
            OP_SRL:   y_comb = A >> shamt;
            OP_SRA:   y_comb = $unsigned($signed(A) >>> shamt);
            OP_ADD: begin
                y_comb = sum;
                v_comb = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                y_comb = diff;
                v_comb = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:   y_comb = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  y_comb = {{(WIDTH-1){1'b0}}, (A < B)};
            default: begin
                y_comb = '0;
                v_comb = 1'b0;
            end
        endcase
    end

    // Output register update: iterative result in FINISH, else accepted single-cycle op.
    always_comb begin
        y_d    = y_q;
        y_hi_d = y_hi_q;
        z_d    = z_q;
        v_d    = v_q;
        n_d    = n_q;
        done_d = 1'b0;
        if (md_fin) begin
            y_d    = md_lo;
            y_hi_d = md_hi;
            z_d    = md_z;
            v_d    = md_v;
            n_d    = md_n;
            done_d = 1'b1;
        end else if (start && ready && !op_is_md) begin
            y_d    = y_comb;
            y_hi_d = '0;
            z_d    = (y_comb == '0);
            v_d    = v_comb;
            n_d    = y_comb[WIDTH-1];
            done_d = 1'b1;
        end
    end

    // Result and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_q    <= '0;
            y_hi_q <= '0;
            z_q    <= 1'b1;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            y_hi_q <= y_hi_d;
            z_q    <= z_d;
            v_q    <= v_d;
            n_q    <= n_d;
            done_q <= done_d;
        end
    end

    assign Y    = y_q;
    assign Y_hi = y_hi_q;
    assign z    = z_q;
    assign v    = v_q;
    assign n    = n_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); divide checks depend on SEQ_ALU_DIV_EN.
module tb_seq_alu;

    localparam logic [4:0] AND_ = 5'b00000, XOR_ = 5'b00010, NOR_ = 5'b00011;
    localparam logic [4:0] SLL_ = 5'b01000, SRA_ = 5'b01010;
    localparam logic [4:0] ADD_ = 5'b10000, SUB_ = 5'b10001, SLT_ = 5'b10010, SLTU_ = 5'b10011;
    localparam logic [4:0] MULT_ = 5'b11000, MULTU_ = 5'b11001, DIV_ = 5'b11010, DIVU_ = 5'b11011;
    localparam logic [4:0] UNDEF_ = 5'b00101;

    logic        clk, reset, start;
    logic [4:0]  ALUOp;
    logic [31:0] A, B, Y, Y_hi;
    logic        ready, done, z, v, n;

    int vectors = 0;
    int miscompares = 0;
    int k, low, saw;

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ALUOp (ALUOp),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .Y     (Y),
        .Y_hi  (Y_hi),
        .z     (z),
        .v     (v),
        .n     (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: present op for one rising edge, return at next falling edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        ALUOp = op;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Result check of Y, Y_hi and {z,v,n}.
    task automatic chk_res(input string tag, input logic [31:0] y, input logic [31:0] yh, input logic [2:0] zvn);
        chk({tag, "/done"}, done, 1'b1);
        chk({tag, "/Y"}, Y, y);
        chk({tag, "/Y_hi"}, Y_hi, yh);
        chk({tag, "/zvn"}, {z, v, n}, zvn);
    endtask

    // Bounded wait for done; k is the cycle number relative to the start cycle.
    task automatic wait_done(input int k0, output int kk, output int lw);
        kk = k0;
        lw = 0;
        while (done !== 1'b1 && kk < 80) begin
            if (ready === 1'b0) lw++;
            @(negedge clk);
            kk++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ALUOp = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("rst/ready", ready, 1'b1);
        chk("rst/done", done, 1'b0);
        chk("rst/Y", Y, 32'h0);
        chk("rst/Y_hi", Y_hi, 32'h0);
        chk("rst/zvn", {z, v, n}, 3'b100);
        reset = 1'b0;
        @(negedge clk);

        issue(ADD_, 32'h7FFF_FFFF, 32'h1);
        chk_res("add_ovf", 32'h8000_0000, 32'h0, 3'b011);
        chk("add_ovf/ready", ready, 1'b1);
        issue(SUB_, 32'd5, 32'd5);
        chk_res("sub_zero", 32'h0, 32'h0, 3'b100);
        issue(SUB_, 32'h8000_0000, 32'h1);
        chk_res("sub_ovf", 32'h7FFF_FFFF, 32'h0, 3'b010);
        issue(SRA_, 32'h8000_0000, 32'd4);
        chk_res("sra", 32'hF800_0000, 32'h0, 3'b001);
        issue(SLL_, 32'h1, 32'h21);
        chk_res("sll_amt_mask", 32'h2, 32'h0, 3'b000);
        issue(SLT_, 32'hFFFF_FFFF, 32'h1);
        chk_res("slt", 32'h1, 32'h0, 3'b000);
        issue(SLTU_, 32'hFFFF_FFFF, 32'h1);
        chk_res("sltu", 32'h0, 32'h0, 3'b100);
        issue(NOR_, 32'h0, 32'h0);
        chk_res("nor", 32'hFFFF_FFFF, 32'h0, 3'b001);
        issue(XOR_, 32'hA5A5_A5A5, 32'hFFFF_0000);
        chk_res("xor", 32'h5A5A_A5A5, 32'h0, 3'b000);
        issue(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk_res("and", 32'h00F0_1200, 32'h0, 3'b000);
        issue(UNDEF_, 32'd5, 32'd3);
        chk_res("undef", 32'h0, 32'h0, 3'b100);

        // Back-to-back single-cycle issue with start held high.
        start = 1'b1; ALUOp = ADD_; A = 32'd2; B = 32'd3;
        @(negedge clk);
        chk_res("b2b_add", 32'd5, 32'h0, 3'b000);
        ALUOp = SUB_; A = 32'd9; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk_res("b2b_sub", 32'd6, 32'h0, 3'b000);
        @(negedge clk);
        chk("hold/done", done, 1'b0);
        chk("hold/Y", Y, 32'd6);

        // MULT -3*5 with operands changed after launch.
        issue(MULT_, 32'hFFFF_FFFD, 32'd5);
        A = 32'h1234_5678; B = 32'h0;
        wait_done(1, k, low);
        chk("mult/done_cycle", k, 34);
        chk("mult/ready_low", low, 33);
        chk("mult/ready", ready, 1'b1);
        chk_res("mult", 32'hFFFF_FFF1, 32'hFFFF_FFFF, 3'b001);
        // start in the done cycle is accepted.
        issue(ADD_, 32'd10, 32'd20);
        chk_res("add_after_mult", 32'd30, 32'h0, 3'b000);

        issue(MULTU_, 32'hFFFF_FFFF, 32'd2);
        wait_done(1, k, low);
        chk("multu/done_cycle", k, 34);
        chk_res("multu", 32'hFFFF_FFFE, 32'h1, 3'b000);

`ifdef SEQ_ALU_DIV_EN
        issue(DIVU_, 32'd100, 32'd7);
        wait_done(1, k, low);
        chk("divu/done_cycle", k, 34);
        chk_res("divu", 32'd14, 32'd2, 3'b000);
        issue(DIV_, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, k, low);
        chk_res("div_neg", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3'b001);
        issue(DIV_, 32'd5, 32'd0);
        wait_done(1, k, low);
        chk_res("div_by_zero", 32'hFFFF_FFFF, 32'd5, 3'b011);
        issue(DIV_, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, k, low);
        chk_res("div_min_m1", 32'h8000_0000, 32'h0, 3'b011);
`else
        issue(DIVU_, 32'd100, 32'd7);
        chk("divu_off/ready", ready, 1'b1);
        chk_res("divu_off", 32'h0, 32'h0, 3'b100);
        issue(DIV_, 32'd5, 32'd0);
        chk_res("div_off", 32'h0, 32'h0, 3'b100);
`endif

        // start while busy is ignored.
        issue(MULT_, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; ALUOp = ADD_; A = 32'd1; B = 32'd2;
        @(negedge clk);
        start = 1'b0;
        chk("ignored/done", done, 1'b0);
        chk("ignored/ready", ready, 1'b0);
        wait_done(6, k, low);
        chk("ignored/done_cycle", k, 34);
        chk_res("ignored_mult", 32'd42, 32'h0, 3'b000);

        // Reset mid-operation aborts without a done pulse.
        issue(MULT_, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort/done", done, 1'b0);
        chk("abort/ready", ready, 1'b1);
        chk("abort/Y", Y, 32'h0);
        chk("abort/Y_hi", Y_hi, 32'h0);
        chk("abort/zvn", {z, v, n}, 3'b100);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1;
        end
        chk("abort/no_done", saw, 0);
        issue(ADD_, 32'd1, 32'd2);
        chk_res("add_after_abort", 32'd3, 32'h0, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
